// File: rtl/timer_nch.sv
// Multi-channel programmable down-counter timer: per-channel one-shot, periodic
// or square-wave mode, sticky terminal status and one combined maskable interrupt.
module timer_nch #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   tick,
  input  logic             we,
  input  logic [1:0]       reg_sel,
  input  logic [CW-1:0]    ch,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [NCH-1:0]   out,
  output logic             irq
);
  typedef enum logic [1:0] {
    MODE_STOP     = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_PERIODIC = 2'b10,
    MODE_SQUARE   = 2'b11
  } mode_t;

  logic [WIDTH-1:0] load_val  [NCH];
  logic [WIDTH-1:0] count_val [NCH];
  mode_t            mode_val  [NCH];
  logic [NCH-1:0]   irq_en;
  logic [NCH-1:0]   running;
  logic [NCH-1:0]   status;
  logic [NCH-1:0]   load_wr;
  logic [NCH-1:0]   ctrl_wr;
  logic [NCH-1:0]   clr_mask;
  logic [WIDTH-1:0] status_rd;
  logic             ch_ok;

  assign ch_ok = int'(ch) < NCH;

  // NCH may exceed WIDTH (e.g. 16 channels on an 8-bit bus), so the status
  // bits are fitted to the data width in both directions.
  if (NCH <= WIDTH) begin : g_narrow
    assign clr_mask  = wdata[NCH-1:0];
    assign status_rd = WIDTH'(status);
  end else begin : g_wide
    assign clr_mask  = {{(NCH-WIDTH){1'b0}}, wdata};
    assign status_rd = status[WIDTH-1:0];
  end

  always_comb begin
    load_wr = '0;
    ctrl_wr = '0;
    for (int i = 0; i < NCH; i++) begin
      load_wr[i] = we && ch_ok && (int'(ch) == i) && (reg_sel == 2'd0);
      ctrl_wr[i] = we && ch_ok && (int'(ch) == i) && (reg_sel == 2'd1);
    end
  end

  // A register write to a channel swallows that channel's tick in the same
  // cycle; a terminal event beats a simultaneous status clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        load_val[i]  <= '0;
        count_val[i] <= '0;
        mode_val[i]  <= MODE_STOP;
      end
      irq_en  <= '0;
      running <= '0;
      status  <= '0;
      out     <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load_wr[i]) begin
          load_val[i]  <= wdata;
          count_val[i] <= wdata;
          out[i]       <= 1'b0;
          running[i]   <= (mode_val[i] != MODE_STOP);
        end else if (ctrl_wr[i]) begin
          mode_val[i] <= mode_t'(wdata[1:0]);
          irq_en[i]   <= wdata[2];
          out[i]      <= 1'b0;
          running[i]  <= (wdata[1:0] != 2'b00);
        end else begin
          if (mode_val[i] == MODE_PERIODIC) out[i] <= 1'b0;
          if (tick[i] && running[i]) begin
            if (count_val[i] != '0) begin
              count_val[i] <= count_val[i] - WIDTH'(1);
            end else begin
              case (mode_val[i])
                MODE_ONESHOT: begin
                  running[i] <= 1'b0;
                  out[i]     <= 1'b1;
                end
                MODE_PERIODIC: begin
                  count_val[i] <= load_val[i];
                  out[i]       <= 1'b1;
                end
                MODE_SQUARE: begin
                  count_val[i] <= load_val[i];
                  out[i]       <= ~out[i];
                end
                default: running[i] <= 1'b0;
              endcase
            end
          end
        end
        if (we && (reg_sel == 2'd2) && clr_mask[i]) status[i] <= 1'b0;
        if (!load_wr[i] && !ctrl_wr[i] && tick[i] && running[i] && (count_val[i] == '0))
          status[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: begin
        for (int i = 0; i < NCH; i++)
          if (ch_ok && (int'(ch) == i)) rdata = count_val[i];
      end
      2'd1: begin
        for (int i = 0; i < NCH; i++)
          if (ch_ok && (int'(ch) == i)) rdata = WIDTH'({irq_en[i], mode_val[i]});
      end
      2'd2:    rdata = status_rd;
      default: rdata = '0;
    endcase
  end

  assign irq = |(status & irq_en);

endmodule

// File: doc/timer_nch.md
# timer_nch

Parametrised multi-channel programmable timer, the successor to the fixed three-channel counter peripheral on the MIO bus. Provides NCH independent down-counters, each with its own count-enable tick, selectable one-shot/periodic/square-wave mode, sticky terminal flags and a combined maskable interrupt line for the pipelined CPU. It sits on the I/O clock beside the bus decoder, which drives its write strobe, register/channel selects and data, and reads its counts back.

## Interface
- NCH, 4: number of channels (1..16)
- WIDTH, 32: counter/load width in bits (8..32)
- CW, derived: channel-select width, max(1, clog2(NCH))
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  NCH  per-channel count enable; bit i high for one cycle = one count event for channel i
- we  in  1  register write strobe
- reg_sel  in  2  register select: 0 load/count, 1 ctrl, 2 status, 3 reserved
- ch  in  CW  channel select for reg_sel 0/1; ignored for reg_sel 2
- wdata  in  WIDTH  write data
- rdata  out  WIDTH  read data for (reg_sel, ch); combinational from registered state
- out  out  NCH  per-channel timer output
- irq  out  1  OR over channels of (status[i] & irq_en[i])

## Operation
- Per channel: load[WIDTH], count[WIDTH], mode[1:0], irq_en, running, status, out.
- Modes: 00 stop, 01 one-shot, 10 periodic, 11 square wave.
- Write reg_sel 0: load<=wdata, count<=wdata, out<=0; running<=(mode!=00).
- Write reg_sel 1: mode<=wdata[1:0], irq_en<=wdata[2]; out<=0; running<=(wdata[1:0]!=00); count unchanged (one-shot restarts from current count).
- Write reg_sel 2: status[i]<=0 for every i where wdata[i]=1 (write-1-to-clear).
- Write reg_sel 3: ignored. Writes with ch>=NCH ignored.
- Count event (tick[i] & running[i], no write to channel i this cycle):
  - count!=0: count<=count-1.
  - count==0 (terminal event): status<=1; then per mode:
    - one-shot: count stays 0, running<=0, out<=1 (held until next load/ctrl write).
    - periodic: count<=load, out high for exactly one cycle.
    - square: count<=load, out toggles.
- Period = load+1 ticks; load=0 in periodic gives a terminal event on every tick.
- Ticks while running=0 or mode=00 are ignored.
- Reads: reg_sel 0 -> count[ch]; 1 -> {zeros, irq_en, mode}; 2 -> {zeros, status[NCH-1:0]}; 3 or ch>=NCH -> 0.
- Reset values: all load/count=0, mode=00, irq_en=0, running=0, status=0, out=0, irq=0, rdata=0.

## Timing
- Writes take effect at the clock edge sampling we; rdata reflects the new value the following cycle.
- Terminal event detected at edge sampling tick with count==0; out/status update at that same edge, visible next cycle; irq follows status combinationally (same cycle as status).
- Periodic out pulse is exactly one clk cycle wide regardless of tick width.
- Write to a channel and its tick in the same cycle: write wins, tick lost.
- Status clear and terminal event on same channel same cycle: set wins (status stays 1).
- Channels are independent; simultaneous terminal events on several channels all set their status bits.
- rst overrides everything, including mid-count and pending writes; counting resumes only after a fresh load/ctrl write.

## Test plan
- Reset: assert rst 2 cycles with ticks active -> count=0, out=0, status=0, irq=0, rdata=0 on all channels.
- Periodic: ch1 ctrl=0b110 (periodic, irq_en), load=3, tick every cycle -> out[1] one-cycle pulse every 4 ticks, status[1]=1, irq=1; write reg_sel 2 wdata=0x2 -> irq=0 next cycle.
- One-shot: ch0 mode=01, load=2, 5 ticks -> out[0] rises after 3rd tick, holds 1, count stays 0; ctrl rewrite -> out[0]=0.
- Square: ch2 mode=11, load=1, continuous ticks -> out[2] toggles every 2 ticks (period 4 ticks).
- Collisions: load write and tick to ch3 same cycle -> count=load, no decrement; clear and terminal event same cycle -> status remains 1.
- Parameters: NCH=1, WIDTH=8, load=0xFF periodic -> terminal event every 256 ticks, count wraps to 0xFF, reads with ch=1 ignored/return 0.
